reaction_timer: RTL and testbench
=================================

// Module: reaction_timer
// PURPOSE
//  Consumes the 8-bit LFSR value to run one reaction-time trial: waits a random
//  delay (MIN_DELAY_MS + rnd*STEP_MS), lights the stimulus LED, then counts ms
//  until the player presses the response button.
//  Sits between the LFSR (upstream, rnd_in/rng_step) and the 7-seg display (rt_ms).
//  Flags presses made before the LED lights (early) and responses that never come (timeout).
// PARAMETERS
//  TICK_DIV      50000  clk cycles per 1 ms tick (50 MHz clk)
//  MIN_DELAY_MS  1000   fixed part of the random delay, ms
//  STEP_MS       16     ms added per LSB of rnd_in (max delay 1000+255*16=5080 ms)
//  DLY_W         13     delay counter width; MIN_DELAY_MS+255*STEP_MS must fit
//  RT_MAX        9999   reaction count saturation / timeout value, ms
//  RT_W          14     rt_ms width
// PORTS
//  clk       in   1     system clock
//  rst       in   1     asynchronous, active-low reset
//  start     in   1     debounced start button, level; rising edge used
//  resp      in   1     debounced response button, level; rising edge used
//  rnd_in    in   8     current LFSR value
//  rng_step  out  1     step enable to LFSR (its start input)
//  led       out  1     stimulus LED
//  busy      out  1     trial in progress (DELAY or STIM)
//  done      out  1     one-cycle pulse when a trial ends
//  early     out  1     last trial ended by a press during DELAY
//  timeout   out  1     last trial reached RT_MAX without a press
//  rt_ms     out  RT_W  last reaction time, ms
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; led,busy,done,early,timeout=0; rt_ms=0;
//   prescaler, counters and edge-detect registers cleared (edge regs load 0, so
//   a button held through reset release gives one rising edge).
//  Edge detect: start_re = start & ~start_q; resp_re likewise; registered 1 cycle.
//  rng_step = 1 in IDLE and RESULT, else 0 (LFSR free-runs between trials).
//  States: IDLE -> DELAY -> STIM -> RESULT; RESULT -> DELAY on start_re.
//  IDLE/RESULT: on start_re at edge N: dly <= MIN_DELAY_MS + rnd_in*STEP_MS
//   (rnd_in sampled at edge N, DLY_W-bit unsigned), prescaler<=0, early,timeout<=0,
//   state<=DELAY. busy=1 from N+1. rt_ms holds previous result until next done.
//  Tick: prescaler counts 0..TICK_DIV-1 in DELAY/STIM; tick=1 on TICK_DIV-1, wraps.
//  DELAY: each tick dly<=dly-1; tick while dly==1 -> STIM, rt_cnt<=0, led=1 next cycle.
//   resp_re in DELAY -> RESULT, early<=1, rt_ms<=0, done=1, led stays 0.
//  STIM: each tick rt_cnt<=rt_cnt+1 (saturate at RT_MAX).
//   resp_re -> RESULT, rt_ms<=rt_cnt, led<=0, done=1 (same cycle as state change).
//   rt_cnt reaches RT_MAX -> RESULT, timeout<=1, rt_ms<=RT_MAX, led<=0, done=1.
//  Priority same cycle: resp_re over tick (press wins; in DELAY counts as early).
//  start_re during DELAY/STIM is ignored. resp_re in IDLE/RESULT is ignored.
//  done is exactly 1 cycle; busy=0 in IDLE/RESULT.
//  Reset mid-trial: immediate return to reset values, no done pulse.
// STRUCTURE
//  constants.vh: state encodings (IDLE=2'd0, DELAY=2'd1, STIM=2'd2, RESULT=2'd3)
//   and default timing constants shared with the display/top level.
//  Sub-module ms_tick: prescaler (clk, rst, clr, en -> tick), param TICK_DIV.
//  Single FSM always block + registered outputs in reaction_timer.
// TESTING (bench params TICK_DIV=4, MIN_DELAY_MS=10, STEP_MS=1, RT_MAX=50)
//  1 Reset: drive rst=0 mid-STIM -> led,busy,done,rt_ms=0 immediately; state IDLE.
//  2 Normal: rnd_in=8'h05, start edge, resp edge 12 ticks after led rises ->
//    led high 15 ticks (60 clks) after start, done pulse 1 clk, rt_ms=12, early=0.
//  3 Early: rnd_in=8'h05, resp edge 3 ticks after start -> done, early=1,
//    rt_ms=0, led never asserts.
//  4 Timeout: no resp after led -> after 50 ticks done, timeout=1, rt_ms=50, led=0.
//  5 Ignored events: start edge during DELAY, resp edge in IDLE -> no state change,
//    delay still ends at original time; rng_step=1 only in IDLE/RESULT.
//  6 Boundary: rnd_in=8'hFF -> led after 265 ticks; resp_re on same cycle as the
//    final DELAY tick -> early=1 (press wins).

Source files
------------

// File: rtl/reaction_timer_pkg.sv
// Shared state encoding, default timing constants and the trial-delay helper
// for the reaction timer and its display/top level.
package reaction_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_STIM   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_MIN_DELAY_MS = 1000;
  localparam int DEF_STEP_MS      = 16;
  localparam int DEF_DLY_W        = 13;
  localparam int DEF_RT_MAX       = 9999;
  localparam int DEF_RT_W         = 14;

  // Random pre-stimulus delay in ms; caller truncates to its counter width.
  function automatic logic [31:0] trial_delay(input logic [7:0]  rnd,
                                              input int unsigned min_ms,
                                              input int unsigned step_ms);
    return 32'(min_ms) + 32'(rnd) * 32'(step_ms);
  endfunction

endpackage

// File: rtl/reaction_timer_if.sv
// Button/LFSR inputs and LED/status/result outputs of one reaction timer.
interface reaction_timer_if #(
  parameter int RT_W = 14
);
  logic            start;
  logic            resp;
  logic [7:0]      rnd_in;
  logic            rng_step;
  logic            led;
  logic            busy;
  logic            done;
  logic            early;
  logic            timeout;
  logic [RT_W-1:0] rt_ms;

  modport master (
    output start, resp, rnd_in,
    input  rng_step, led, busy, done, early, timeout, rt_ms
  );

  modport slave (
    input  start, resp, rnd_in,
    output rng_step, led, busy, done, early, timeout, rt_ms
  );
endinterface

// File: rtl/reaction_timer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every TICK_DIV enabled clocks.
module reaction_timer_ms_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// One reaction-time trial: random delay, stimulus LED, then ms count until the
// response press; flags early presses and missing responses.
module reaction_timer
  import reaction_timer_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int STEP_MS      = DEF_STEP_MS,
  parameter int DLY_W        = DEF_DLY_W,
  parameter int RT_MAX       = DEF_RT_MAX,
  parameter int RT_W         = DEF_RT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  reaction_timer_if.slave tmr_if
);

  localparam logic [RT_W-1:0]  RT_MAX_V  = RT_W'(RT_MAX);
  localparam logic [RT_W-1:0]  RT_LAST_V = RT_W'(RT_MAX - 1);
  localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);

  state_e            state_q, state_d;
  logic              start_q, resp_q;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [RT_W-1:0]   rt_cnt_q, rt_cnt_d;
  logic [RT_W-1:0]   rt_ms_q, rt_ms_d;
  logic              led_q, led_d;
  logic              done_q, done_d;
  logic              early_q, early_d;
  logic              timeout_q, timeout_d;

  logic start_re, resp_re, busy, tick, pre_clr;

  assign start_re = tmr_if.start & ~start_q;
  assign resp_re  = tmr_if.resp & ~resp_q;
  assign busy     = (state_q == ST_DELAY) || (state_q == ST_STIM);

  reaction_timer_ms_tick #(.TICK_DIV(TICK_DIV)) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (pre_clr),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    rt_cnt_d  = rt_cnt_q;
    rt_ms_d   = rt_ms_q;
    led_d     = led_q;
    done_d    = 1'b0;
    early_d   = early_q;
    timeout_d = timeout_q;
    pre_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (start_re) begin
          dly_d     = DLY_W'(trial_delay(tmr_if.rnd_in, MIN_DELAY_MS, STEP_MS));
          pre_clr   = 1'b1;
          early_d   = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_DELAY;
        end
      end
      ST_DELAY: begin
        // A press on the very tick that would light the LED still counts as early.
        if (resp_re) begin
          state_d = ST_RESULT;
          early_d = 1'b1;
          rt_ms_d = '0;
          done_d  = 1'b1;
        end else if (tick) begin
          if (dly_q <= DLY_ONE) begin
            state_d  = ST_STIM;
            rt_cnt_d = '0;
            led_d    = 1'b1;
          end else begin
            dly_d = dly_q - 1'b1;
          end
        end
      end
      ST_STIM: begin
        if (resp_re) begin
          state_d = ST_RESULT;
          rt_ms_d = rt_cnt_q;
          led_d   = 1'b0;
          done_d  = 1'b1;
        end else if (tick) begin
          if (rt_cnt_q >= RT_LAST_V) begin
            state_d   = ST_RESULT;
            rt_cnt_d  = RT_MAX_V;
            rt_ms_d   = RT_MAX_V;
            timeout_d = 1'b1;
            led_d     = 1'b0;
            done_d    = 1'b1;
          end else begin
            rt_cnt_d = rt_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      resp_q    <= 1'b0;
      dly_q     <= '0;
      rt_cnt_q  <= '0;
      rt_ms_q   <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= tmr_if.start;
      resp_q    <= tmr_if.resp;
      dly_q     <= dly_d;
      rt_cnt_q  <= rt_cnt_d;
      rt_ms_q   <= rt_ms_d;
      led_q     <= led_d;
      done_q    <= done_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign tmr_if.rng_step = (state_q == ST_IDLE) || (state_q == ST_RESULT);
  assign tmr_if.busy     = busy;
  assign tmr_if.led      = led_q;
  assign tmr_if.done     = done_q;
  assign tmr_if.early    = early_q;
  assign tmr_if.timeout  = timeout_q;
  assign tmr_if.rt_ms    = rt_ms_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a 4-clock ms tick and short delays.
module tb_reaction_timer;

  localparam int TICK_DIV     = 4;
  localparam int MIN_DELAY_MS = 10;
  localparam int STEP_MS      = 1;
  localparam int RT_MAX       = 50;
  localparam int RT_W         = 14;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic led_seen;

  reaction_timer_if #(.RT_W(RT_W)) tmr_if ();

  reaction_timer #(
    .TICK_DIV     (TICK_DIV),
    .MIN_DELAY_MS (MIN_DELAY_MS),
    .STEP_MS      (STEP_MS),
    .DLY_W        (13),
    .RT_MAX       (RT_MAX),
    .RT_W         (RT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tmr_if (tmr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rising start edge accepted on the next clock; returns 1 ns after it.
  task automatic press_start(input logic [7:0] rnd);
    tmr_if.rnd_in = rnd;
    tmr_if.start  = 1'b1;
    step(1);
    tmr_if.start  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    tmr_if.start  = 1'b0;
    tmr_if.resp   = 1'b0;
    tmr_if.rnd_in = 8'h00;
    #2;
    check_val("rst_led", 32'(tmr_if.led), 0);
    check_val("rst_busy", 32'(tmr_if.busy), 0);
    check_val("rst_done", 32'(tmr_if.done), 0);
    check_val("rst_rt_ms", 32'(tmr_if.rt_ms), 0);
    check_val("rst_rng_step", 32'(tmr_if.rng_step), 1);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Normal trial: delay 15 ticks, response 12 ticks after the LED.
    press_start(8'h05);
    check_val("n_busy", 32'(tmr_if.busy), 1);
    check_val("n_rng_step", 32'(tmr_if.rng_step), 0);
    step(59);
    check_val("n_led_59", 32'(tmr_if.led), 0);
    step(1);
    check_val("n_led_60", 32'(tmr_if.led), 1);
    step(49);
    tmr_if.resp = 1'b1;
    step(1);
    tmr_if.resp = 1'b0;
    check_val("n_done", 32'(tmr_if.done), 1);
    check_val("n_rt_ms", 32'(tmr_if.rt_ms), 12);
    check_val("n_early", 32'(tmr_if.early), 0);
    check_val("n_led_off", 32'(tmr_if.led), 0);
    check_val("n_busy_off", 32'(tmr_if.busy), 0);
    step(1);
    check_val("n_done_1clk", 32'(tmr_if.done), 0);
    check_val("n_rt_hold", 32'(tmr_if.rt_ms), 12);

    // Early press 3 ticks into the delay.
    press_start(8'h05);
    step(12);
    tmr_if.resp = 1'b1;
    step(1);
    tmr_if.resp = 1'b0;
    check_val("e_done", 32'(tmr_if.done), 1);
    check_val("e_early", 32'(tmr_if.early), 1);
    check_val("e_rt_ms", 32'(tmr_if.rt_ms), 0);
    led_seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      step(1);
      led_seen = led_seen | tmr_if.led;
    end
    check_val("e_led_never", 32'(led_seen), 0);
    check_val("e_done_low", 32'(tmr_if.done), 0);

    // Timeout: delay 10 ticks, no response for 50 ticks.
    press_start(8'h00);
    check_val("t_early_clr", 32'(tmr_if.early), 0);
    step(40);
    check_val("t_led_on", 32'(tmr_if.led), 1);
    step(199);
    check_val("t_done_pre", 32'(tmr_if.done), 0);
    step(1);
    check_val("t_done", 32'(tmr_if.done), 1);
    check_val("t_timeout", 32'(tmr_if.timeout), 1);
    check_val("t_rt_ms", 32'(tmr_if.rt_ms), 50);
    check_val("t_led_off", 32'(tmr_if.led), 0);
    step(1);

    // Ignored events: response in RESULT, start during DELAY.
    tmr_if.resp = 1'b1;
    step(1);
    tmr_if.resp = 1'b0;
    check_val("i_busy_res", 32'(tmr_if.busy), 0);
    check_val("i_done_res", 32'(tmr_if.done), 0);
    check_val("i_rng_res", 32'(tmr_if.rng_step), 1);
    check_val("i_rt_hold", 32'(tmr_if.rt_ms), 50);
    press_start(8'h02);
    tmr_if.rnd_in = 8'hFF;
    check_val("i_rng_dly", 32'(tmr_if.rng_step), 0);
    check_val("i_timeout_clr", 32'(tmr_if.timeout), 0);
    step(9);
    tmr_if.start = 1'b1;
    step(1);
    tmr_if.start = 1'b0;
    check_val("i_busy_dly", 32'(tmr_if.busy), 1);
    step(37);
    check_val("i_led_47", 32'(tmr_if.led), 0);
    step(1);
    check_val("i_led_48", 32'(tmr_if.led), 1);
    check_val("i_rng_stim", 32'(tmr_if.rng_step), 0);
    tmr_if.resp = 1'b1;
    step(1);
    tmr_if.resp = 1'b0;
    check_val("i_done", 32'(tmr_if.done), 1);
    check_val("i_early", 32'(tmr_if.early), 0);
    step(1);

    // Boundary: max delay, press on the final delay tick counts as early.
    press_start(8'hFF);
    step(1059);
    check_val("b_led_pre", 32'(tmr_if.led), 0);
    tmr_if.resp = 1'b1;
    step(1);
    tmr_if.resp = 1'b0;
    check_val("b_done", 32'(tmr_if.done), 1);
    check_val("b_early", 32'(tmr_if.early), 1);
    check_val("b_led_off", 32'(tmr_if.led), 0);
    step(1);

    // Max delay without a press lights at 265 ticks, then reset mid-STIM.
    press_start(8'hFF);
    step(1059);
    check_val("r_led_1059", 32'(tmr_if.led), 0);
    step(1);
    check_val("r_led_1060", 32'(tmr_if.led), 1);
    step(5);
    check_val("r_busy_stim", 32'(tmr_if.busy), 1);
    rst_n = 1'b0;
    #2;
    check_val("r_led", 32'(tmr_if.led), 0);
    check_val("r_busy", 32'(tmr_if.busy), 0);
    check_val("r_done", 32'(tmr_if.done), 0);
    check_val("r_rt_ms", 32'(tmr_if.rt_ms), 0);
    check_val("r_early", 32'(tmr_if.early), 0);
    check_val("r_rng_idle", 32'(tmr_if.rng_step), 1);
    tmr_if.start = 1'b1;
    step(2);
    check_val("r_busy_held", 32'(tmr_if.busy), 0);
    rst_n = 1'b1;
    step(1);
    check_val("r_held_start", 32'(tmr_if.busy), 1);
    check_val("r_no_done", 32'(tmr_if.done), 0);
    tmr_if.start = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
